// File: rtl/vsa_param_core.sv
// rtl/vsa_param_core.sv - multi-cycle VSA core, IF/ID/EX/MEM/WB with imem/dmem ack stalls
// Moore outputs are registered from the next state so they change with the state flop.
module vsa_param_core #(
    parameter int DW   = 5,
    parameter int NREG = 4,
    parameter int RAW  = $clog2(NREG),
    parameter int IW   = 3*RAW+6
) (
    input  logic          clock,
    input  logic          reset,
    output logic [DW-1:0] PC,
    output logic          imem_req,
    input  logic          imem_ack,
    input  logic [IW-1:0] instruction,
    output logic [DW-1:0] ALUOutput,
    output logic          dmem_req,
    input  logic          dmem_ack,
    input  logic [DW-1:0] datain,
    output logic [DW-1:0] dataout,
    output logic          wr,
    output logic          retire
);
    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_t;

    localparam logic [2:0] OP_LW   = 3'd0;
    localparam logic [2:0] OP_SW   = 3'd1;
    localparam logic [2:0] OP_BEQZ = 3'd2;
    localparam logic [2:0] OP_ALU  = 3'd3;
    localparam logic [2:0] OP_ADDI = 3'd4;
    localparam logic [2:0] OP_SUBI = 3'd5;
    localparam logic [DW-1:0] PC_STEP = {{(DW-2){1'b0}}, 2'b10};

    state_t        state_q, state_d;
    logic [DW-1:0] pc_q, pc_d, npc_q, npc_d;
    logic [IW-1:0] ir_q, ir_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d, lmd_q, lmd_d;
    logic          cond_q, cond_d;
    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic          imem_req_q, imem_req_d, dmem_req_q, dmem_req_d;
    logic          wr_q, wr_d, retire_q, retire_d;

    logic [2:0]     op, fn;
    logic [RAW-1:0] s1, s2, rd_r;
    logic [RAW+2:0] imm_raw;
    logic [DW-1:0]  imm, br_off, rd_a, rd_b, alu_res;
    logic           is_mem;
    logic           wen;
    logic [RAW-1:0] wdst;
    logic [DW-1:0]  wval;

    // s2 doubles as the destination field of I-format instructions
    assign op      = ir_q[IW-1 -: 3];
    assign s1      = ir_q[IW-4 -: RAW];
    assign s2      = ir_q[2*RAW+2 -: RAW];
    assign rd_r    = ir_q[RAW+2 -: RAW];
    assign fn      = ir_q[2:0];
    assign imm_raw = ir_q[RAW+2:0];
    assign is_mem  = (op == OP_LW) || (op == OP_SW);
    assign rd_a    = (s1 == '0) ? '0 : regs_q[s1];
    assign rd_b    = (s2 == '0) ? '0 : regs_q[s2];

    always_comb begin
        imm = '0;
        imm[RAW+2:0] = imm_raw;
        br_off = '0;
        br_off[RAW+3:0] = {imm_raw, 1'b0};
    end

    always_comb begin
        alu_res = '0;
        case (fn)
            3'd0: alu_res = a_q + b_q;
            3'd1: alu_res = a_q - b_q;
            3'd2: alu_res = a_q & b_q;
            3'd3: alu_res = a_q | b_q;
            3'd4: alu_res = a_q ^ b_q;
            3'd5: alu_res = ~a_q;
            3'd6: alu_res = a_q >> 1;
            default: alu_res = {a_q[DW-1], a_q[DW-1:1]};
        endcase
    end

    always_comb begin
        wen  = 1'b0;
        wdst = '0;
        wval = '0;
        case (op)
            OP_ALU: begin
                wen  = 1'b1;
                wdst = rd_r;
                wval = alu_q;
            end
            OP_ADDI, OP_SUBI: begin
                wen  = 1'b1;
                wdst = s2;
                wval = alu_q;
            end
            OP_LW: begin
                wen  = 1'b1;
                wdst = s2;
                wval = lmd_q;
            end
            default: wen = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        npc_d   = npc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        alu_d   = alu_q;
        cond_d  = cond_q;
        lmd_d   = lmd_q;
        regs_d  = regs_q;
        case (state_q)
            S_IF: begin
                if (imem_ack) begin
                    ir_d    = instruction;
                    npc_d   = pc_q + PC_STEP;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                a_d     = rd_a;
                b_d     = rd_b;
                state_d = S_EX;
            end
            S_EX: begin
                case (op)
                    OP_LW, OP_SW, OP_ADDI: alu_d = a_q + imm;
                    OP_SUBI:               alu_d = a_q - imm;
                    OP_ALU:                alu_d = alu_res;
                    OP_BEQZ: begin
                        alu_d  = npc_q + br_off;
                        cond_d = (a_q == '0);
                    end
                    default: alu_d = alu_q;
                endcase
                state_d = S_MEM;
            end
            S_MEM: begin
                if (is_mem) begin
                    if (dmem_ack) begin
                        if (op == OP_LW) lmd_d = datain;
                        pc_d    = npc_q;
                        state_d = S_WB;
                    end
                end else begin
                    pc_d    = (op == OP_BEQZ && cond_q) ? alu_q : npc_q;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (wen && wdst != '0) regs_d[wdst] = wval;
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase

        imem_req_d = (state_d == S_IF);
        dmem_req_d = (state_d == S_MEM) && is_mem;
        wr_d       = (state_d == S_MEM) && (op == OP_SW);
        retire_d   = (state_d == S_WB);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IF;
            pc_q       <= '0;
            npc_q      <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            alu_q      <= '0;
            cond_q     <= 1'b0;
            lmd_q      <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            imem_req_q <= 1'b1;
            dmem_req_q <= 1'b0;
            wr_q       <= 1'b0;
            retire_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            npc_q      <= npc_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            alu_q      <= alu_d;
            cond_q     <= cond_d;
            lmd_q      <= lmd_d;
            regs_q     <= regs_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            wr_q       <= wr_d;
            retire_q   <= retire_d;
        end
    end

    assign PC        = pc_q;
    assign ALUOutput = alu_q;
    assign dataout   = b_q;
    assign imem_req  = imem_req_q;
    assign dmem_req  = dmem_req_q;
    assign wr        = wr_q;
    assign retire    = retire_q;
endmodule

// File: tb/tb_vsa_param_core.sv
// tb/tb_vsa_param_core.sv - bench for vsa_param_core, default and DW=8/NREG=8 instances
module tb_vsa_param_core;
    logic        clock;
    logic        rst_a, rst_b;
    logic [4:0]  pc_a, alu_a, din_a, dout_a;
    logic [11:0] instruction;
    logic        imem_ack, dmem_ack, imem_req_a, dmem_req_a, wr_a, retire_a;
    logic [7:0]  pc_b, alu_b, dout_b;
    logic [14:0] instr_b;
    logic        imem_req_b, dmem_req_b, wr_b, retire_b;
    logic [14:0] bprog [16];

    typedef struct {
        logic [11:0] instr;
        int          istall;
        int          dstall;
        logic [4:0]  din;
        logic [4:0]  pc;
        bit          mem;
        bit          wr;
        logic [4:0]  addr;
        logic [4:0]  dout;
        int          cyc;
    } vec_t;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] dout;
    } mexp_t;

    mexp_t sb_q[$];
    vec_t  tv[28];
    int    n_cmp = 0;
    int    n_err = 0;

    vsa_param_core dut_a (
        .clock(clock), .reset(rst_a), .PC(pc_a), .imem_req(imem_req_a), .imem_ack(imem_ack),
        .instruction(instruction), .ALUOutput(alu_a), .dmem_req(dmem_req_a), .dmem_ack(dmem_ack),
        .datain(din_a), .dataout(dout_a), .wr(wr_a), .retire(retire_a)
    );

    vsa_param_core #(.DW(8), .NREG(8)) dut_b (
        .clock(clock), .reset(rst_b), .PC(pc_b), .imem_req(imem_req_b), .imem_ack(1'b1),
        .instruction(instr_b), .ALUOutput(alu_b), .dmem_req(dmem_req_b), .dmem_ack(1'b1),
        .datain(8'h55), .dataout(dout_b), .wr(wr_b), .retire(retire_b)
    );

    assign instr_b = bprog[pc_b[4:1]];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [11:0] ia(int op, int s1, int d, int imm);
        return {op[2:0], s1[1:0], d[1:0], imm[4:0]};
    endfunction

    function automatic logic [11:0] ra(int s1, int s2, int d, int fn);
        return {3'd3, s1[1:0], s2[1:0], d[1:0], fn[2:0]};
    endfunction

    function automatic logic [14:0] ib(int op, int s1, int d, int imm);
        return {op[2:0], s1[2:0], d[2:0], imm[5:0]};
    endfunction

    function automatic logic [14:0] rb(int s1, int s2, int d, int fn);
        return {3'd3, s1[2:0], s2[2:0], d[2:0], fn[2:0]};
    endfunction

    function automatic vec_t mk(logic [11:0] ins, int is, int ds, int din, int pc,
                                bit mem, bit w, int addr, int dout);
        vec_t t;
        t.instr = ins; t.istall = is; t.dstall = ds; t.din = din[4:0]; t.pc = pc[4:0];
        t.mem = mem; t.wr = w; t.addr = addr[4:0]; t.dout = dout[4:0];
        t.cyc = 5 + is + (mem ? ds : 0);
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input bit w, input int addr, input int dout);
        mexp_t m;
        m.wr = w; m.addr = addr[7:0]; m.dout = dout[7:0];
        sb_q.push_back(m);
    endtask

    // Starts at a falling edge with dut_a in IF; returns at the falling edge of the next IF.
    task automatic exec(input vec_t t, input int idx);
        int n, rc, ds;
        bit done;
        mexp_t m;
        if (t.mem) push_exp(t.wr, int'(t.addr), int'(t.dout));
        instruction = t.instr;
        n = 0;
        for (int i = 0; i < t.istall; i++) begin
            imem_ack = 1'b0;
            @(negedge clock); n++;
        end
        imem_ack = 1'b1;
        @(negedge clock); n++;
        imem_ack = 1'b0;
        rc = 0; ds = 0; done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            if (dmem_req_a) begin
                if (ds == t.dstall) begin
                    if (sb_q.size() == 0) begin
                        chk($sformatf("v%0d unexpected dmem_req", idx), 1, 0);
                    end else begin
                        m = sb_q.pop_front();
                        chk($sformatf("v%0d wr", idx), wr_a, m.wr);
                        chk($sformatf("v%0d addr", idx), alu_a, m.addr);
                        chk($sformatf("v%0d dataout", idx), dout_a, m.dout);
                    end
                    dmem_ack = 1'b1;
                    din_a = t.din;
                end else begin
                    dmem_ack = 1'b0;
                end
                ds++;
            end
            @(negedge clock); n++;
            dmem_ack = 1'b0;
            if (retire_a) rc++;
            if (imem_req_a && rc > 0) done = 1'b1;
        end
        chk($sformatf("v%0d completed", idx), done, 1);
        chk($sformatf("v%0d cycles", idx), n, t.cyc);
        chk($sformatf("v%0d retires", idx), rc, 1);
        chk($sformatf("v%0d PC", idx), pc_a, t.pc);
        if (sb_q.size() != 0) begin
            chk($sformatf("v%0d missing dmem access", idx), sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    initial begin
        int last_k, rcb;
        mexp_t m;
        rst_a = 1'b1; rst_b = 1'b1;
        imem_ack = 1'b0; dmem_ack = 1'b0; din_a = '0; instruction = '0;

        tv[0]  = mk(12'h825,          0, 0, 0,  2, 0, 0, 0,  0);
        tv[1]  = mk(ia(4, 0, 2, 10),  0, 0, 0,  4, 0, 0, 0,  0);
        tv[2]  = mk(ra(1, 2, 3, 3),   0, 0, 0,  6, 0, 0, 0,  0);
        tv[3]  = mk(ia(2, 0, 0, 4),   0, 0, 0, 16, 0, 0, 0,  0);
        tv[4]  = mk(ia(1, 0, 3, 0),   0, 0, 0, 18, 1, 1, 0, 15);
        tv[5]  = mk(ia(2, 0, 0, 9),   0, 0, 0,  6, 0, 0, 0,  0);
        tv[6]  = mk(ia(2, 1, 0, 4),   0, 0, 0,  8, 0, 0, 0,  0);
        tv[7]  = mk(ia(4, 0, 1, 3),   0, 0, 0, 10, 0, 0, 0,  0);
        tv[8]  = mk(ia(4, 0, 2, 5),   0, 0, 0, 12, 0, 0, 0,  0);
        tv[9]  = mk(ra(1, 2, 3, 1),   0, 0, 0, 14, 0, 0, 0,  0);
        tv[10] = mk(ra(1, 2, 0, 1),   0, 0, 0, 16, 0, 0, 0,  0);
        tv[11] = mk(ia(1, 0, 3, 1),   0, 0, 0, 18, 1, 1, 1, 30);
        tv[12] = mk(ia(1, 1, 0, 2),   0, 0, 0, 20, 1, 1, 5,  0);
        tv[13] = mk(ra(1, 2, 3, 4),   0, 0, 0, 22, 0, 0, 0,  0);
        tv[14] = mk(ra(3, 0, 3, 5),   0, 0, 0, 24, 0, 0, 0,  0);
        tv[15] = mk(ra(3, 0, 2, 7),   0, 0, 0, 26, 0, 0, 0,  0);
        tv[16] = mk(ra(3, 0, 1, 6),   0, 0, 0, 28, 0, 0, 0,  0);
        tv[17] = mk(ra(1, 2, 3, 2),   0, 0, 0, 30, 0, 0, 0,  0);
        tv[18] = mk(ia(1, 2, 3, 31),  0, 0, 0,  0, 1, 1, 27, 12);
        tv[19] = mk(ia(5, 1, 1, 13),  0, 0, 0,  2, 0, 0, 0,  0);
        tv[20] = mk(ra(1, 1, 2, 0),   0, 0, 0,  4, 0, 0, 0,  0);
        tv[21] = mk(ia(6, 1, 1, 7),   0, 0, 0,  6, 0, 0, 0,  0);
        tv[22] = mk(ia(7, 2, 2, 1),   0, 0, 0,  8, 0, 0, 0,  0);
        tv[23] = mk(ia(1, 1, 2, 0),   0, 0, 0, 10, 1, 1, 31, 30);
        tv[24] = mk(ia(0, 0, 3, 4),   3, 2, 9, 12, 1, 0, 4, 12);
        tv[25] = mk(ia(1, 0, 3, 0),   1, 1, 0, 14, 1, 1, 0,  9);
        tv[26] = mk(ia(0, 0, 0, 1),   0, 0, 17, 16, 1, 0, 1, 0);
        tv[27] = mk(ia(1, 0, 0, 3),   0, 0, 0, 18, 1, 1, 3,  0);

        repeat (2) @(negedge clock);
        chk("reset imem_req", imem_req_a, 1);
        chk("reset PC", pc_a, 0);
        chk("reset dmem_req", dmem_req_a, 0);
        chk("reset wr", wr_a, 0);
        chk("reset retire", retire_a, 0);
        chk("reset ALUOutput", alu_a, 0);
        rst_a = 1'b0;

        for (int i = 0; i < 28; i++) exec(tv[i], i);

        // Reset while an LW waits in MEM
        instruction = ia(0, 1, 3, 7);
        imem_ack = 1'b1;
        @(negedge clock);
        imem_ack = 1'b0;
        repeat (2) @(negedge clock);
        chk("pre-reset dmem_req", dmem_req_a, 1);
        chk("pre-reset ALUOutput", alu_a, 6);
        #2 rst_a = 1'b1;
        #1;
        chk("mid reset dmem_req", dmem_req_a, 0);
        chk("mid reset wr", wr_a, 0);
        chk("mid reset PC", pc_a, 0);
        chk("mid reset ALUOutput", alu_a, 0);
        chk("mid reset imem_req", imem_req_a, 1);
        @(negedge clock);
        rst_a = 1'b0;
        chk("post reset PC", pc_a, 0);
        exec(mk(ia(1, 1, 3, 2), 0, 0, 0, 2, 1, 1, 2, 0), 99);

        // DW=8, NREG=8 instance running free with both acks high
        bprog[0] = ib(4, 0, 1, 63);
        bprog[1] = rb(1, 1, 1, 0);
        bprog[2] = ib(4, 1, 1, 3);
        bprog[3] = rb(1, 0, 2, 7);
        bprog[4] = rb(1, 0, 3, 6);
        bprog[5] = ib(1, 1, 2, 5);
        bprog[6] = ib(1, 0, 3, 0);
        bprog[7] = ib(0, 0, 4, 2);
        bprog[8] = ib(1, 4, 4, 63);
        for (int i = 9; i < 16; i++) bprog[i] = ib(6, 0, 0, 0);
        push_exp(1, 8'h86, 8'hC0);
        push_exp(1, 8'h00, 8'h40);
        push_exp(0, 8'h02, 8'h00);
        push_exp(1, 8'h94, 8'h55);
        rst_b = 1'b0;
        last_k = -1;
        rcb = 0;
        for (int k = 0; k < 200 && sb_q.size() > 0; k++) begin
            @(negedge clock);
            if (retire_b) rcb++;
            if (dmem_req_b) begin
                m = sb_q.pop_front();
                chk($sformatf("B wr k%0d", k), wr_b, m.wr);
                chk($sformatf("B addr k%0d", k), alu_b, m.addr);
                chk($sformatf("B dataout k%0d", k), dout_b, m.dout);
                last_k = k;
            end
        end
        chk("B accesses drained", sb_q.size(), 0);
        chk("B last access cycle", last_k, 42);
        chk("B retires before last store", rcb, 8);
        rst_b = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
